// File: rtl/spi_sphere_assembler.sv
// spi_sphere_assembler
//
// Builds 64-bit sphere words from the SPI receive byte stream. A word is
// {x16, y14, z16, r6, color12}, sent most significant byte first. Completed
// words wait in a small circular FIFO. While the controller requests data,
// each word is handed over as a one-cycle recv_dv pulse with recv_64bit.
//
// Optional build macro: SPHERE_CHECKSUM_EN
//   When defined, every word is followed by a ninth byte holding the XOR of
//   the eight data bytes. A word is pushed only when that byte matches.
//   When undefined, words are plain 8-byte frames and there is no checksum
//   logic. The ports are the same in both builds.
//
// Parameters:
//   DEPTH    FIFO depth in words (power of two, >= 2)
//   TIMEOUT  idle cycles allowed between bytes of one word
//   CNT_W    width of the saturating error counters
//
// Ports:
//   CLK100MHZ       in   system clock, rising edge
//   ck_rst_         in   asynchronous active-low reset
//   spi_cs_n        in   chip select (synchronous); high ends the frame
//   rx_dv           in   one-cycle strobe, rx_byte valid
//   rx_byte[7:0]    in   received byte
//   recv_interrupt  in   controller is ready to accept a word
//   recv_dv         out  one-cycle strobe, recv_64bit valid
//   recv_64bit      out  delivered sphere word (holds between strobes)
//   fifo_count      out  number of words held in the FIFO
//   overflow        out  sticky: a completed word was dropped (FIFO full)
//   clr_overflow    in   synchronous clear of overflow and ovf_cnt
//   frame_err       out  one-cycle pulse when a partial word is discarded
//   ovf_cnt         out  saturating count of dropped words
//   ferr_cnt        out  saturating count of frame errors
module spi_sphere_assembler #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 100000,
  parameter int CNT_W   = 8
) (
  input  logic                         CLK100MHZ,
  input  logic                         ck_rst_,
  input  logic                         spi_cs_n,
  input  logic                         rx_dv,
  input  logic [7:0]                   rx_byte,
  input  logic                         recv_interrupt,
  output logic                         recv_dv,
  output logic [63:0]                  recv_64bit,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         overflow,
  input  logic                         clr_overflow,
  output logic                         frame_err,
  output logic [CNT_W-1:0]             ovf_cnt,
  output logic [CNT_W-1:0]             ferr_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_FW = $clog2(DEPTH+1);
  localparam int TMO_W = $clog2(TIMEOUT+1);
`ifdef SPHERE_CHECKSUM_EN
  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = 4'd8;
`else
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = 3'd7;
`endif

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IDX_W-1:0]      r_idx;
  logic [TMO_W-1:0]      r_tmo;
  logic [63:0]           r_word;
  logic                  r_push_req;
  logic [63:0]           r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_FW-1:0]     r_count;
  logic                  r_recv_dv;
  logic [63:0]           r_recv_64bit;
  logic                  r_overflow;
  logic                  r_frame_err;
  logic [CNT_W-1:0]      r_ovf_cnt;
  logic [CNT_W-1:0]      r_ferr_cnt;
`ifdef SPHERE_CHECKSUM_EN
  logic [7:0]            r_xor;
`endif

  logic                  w_store;
  logic                  w_done;
  logic                  w_abort;
  logic [2:0]            w_lane;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push_ok;
  logic                  w_drop;

  // Assembly FSM: next state and per-cycle strobes
  always_comb begin
    w_next  = r_state;
    w_store = 1'b0;
    w_done  = 1'b0;
    w_abort = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (rx_dv && !spi_cs_n) begin
          w_store = 1'b1;
          w_next  = COLLECT;
        end
      end
      COLLECT: begin
        if (spi_cs_n) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end else if (rx_dv) begin
`ifdef SPHERE_CHECKSUM_EN
          if (r_idx == LAST_IDX) begin
            // ninth byte is the checksum, never stored in the word
            if (rx_byte == r_xor) w_done  = 1'b1;
            else                  w_abort = 1'b1;
            w_next = IDLE;
          end else begin
            w_store = 1'b1;
          end
`else
          w_store = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_done = 1'b1;
            w_next = IDLE;
          end
`endif
        end else if (r_tmo == TMO_W'(TIMEOUT)) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
    if (!ck_rst_) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_tmo       <= '0;
      r_push_req  <= 1'b0;
      r_frame_err <= 1'b0;
      r_ferr_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == IDLE)  r_idx <= '0;
      else if (w_store)    r_idx <= r_idx + IDX_W'(1);
      // idle-gap timer: only runs while a word is partially collected
      if (r_state == COLLECT && w_next == COLLECT && !w_store)
        r_tmo <= r_tmo + TMO_W'(1);
      else
        r_tmo <= '0;
      r_push_req  <= w_done;
      r_frame_err <= w_abort;
      if (w_abort && r_ferr_cnt != {CNT_W{1'b1}})
        r_ferr_cnt <= r_ferr_cnt + CNT_W'(1);
    end
  end

  // Byte k lands at [63-8k:56-8k]; indexed write is equivalent to shifting.
  assign w_lane = 3'd7 - r_idx[2:0];

  always_ff @(posedge CLK100MHZ) begin
    if (w_store) begin
      r_word[{w_lane, 3'b000} +: 8] <= rx_byte;
`ifdef SPHERE_CHECKSUM_EN
      r_xor <= (r_state == IDLE) ? rx_byte : (r_xor ^ rx_byte);
`endif
    end
  end

  // FIFO: push one cycle after the last byte, pop on delivery
  assign w_full    = (r_count == CNT_FW'(DEPTH));
  assign w_empty   = (r_count == '0);
  // r_recv_dv gate enforces a gap cycle so the controller can drop its request
  assign w_pop     = recv_interrupt && !w_empty && !r_recv_dv;
  assign w_push_ok = r_push_req && (!w_full || w_pop);
  assign w_drop    = r_push_req && w_full && !w_pop;

  // r_word is still the completed word here; a new first byte only lands
  // at this same edge.
  always_ff @(posedge CLK100MHZ) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= r_word;
  end

  always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
    if (!ck_rst_) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_recv_dv    <= 1'b0;
      r_recv_64bit <= '0;
      r_overflow   <= 1'b0;
      r_ovf_cnt    <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_FW'(1);
        2'b01:   r_count <= r_count - CNT_FW'(1);
        default: r_count <= r_count;
      endcase
      r_recv_dv <= w_pop;
      if (w_pop) r_recv_64bit <= r_mem[r_rd_ptr];
      // clear wins over a drop in the same cycle
      if (clr_overflow) begin
        r_overflow <= 1'b0;
        r_ovf_cnt  <= '0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_ovf_cnt != {CNT_W{1'b1}})
          r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
      end
    end
  end

  assign recv_dv    = r_recv_dv;
  assign recv_64bit = r_recv_64bit;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign frame_err  = r_frame_err;
  assign ovf_cnt    = r_ovf_cnt;
  assign ferr_cnt   = r_ferr_cnt;

endmodule

// File: tb/tb_spi_sphere_assembler.sv
// Directed testbench for spi_sphere_assembler (DEPTH=4, TIMEOUT=20).
module tb_spi_sphere_assembler;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 20;
  localparam int CNT_W   = 8;

  logic                       CLK100MHZ = 1'b0;
  logic                       ck_rst_;
  logic                       spi_cs_n;
  logic                       rx_dv;
  logic [7:0]                 rx_byte;
  logic                       recv_interrupt;
  logic                       recv_dv;
  logic [63:0]                recv_64bit;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  logic                       overflow;
  logic                       clr_overflow;
  logic                       frame_err;
  logic [CNT_W-1:0]           ovf_cnt;
  logic [CNT_W-1:0]           ferr_cnt;

  spi_sphere_assembler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK100MHZ      (CLK100MHZ),
    .ck_rst_        (ck_rst_),
    .spi_cs_n       (spi_cs_n),
    .rx_dv          (rx_dv),
    .rx_byte        (rx_byte),
    .recv_interrupt (recv_interrupt),
    .recv_dv        (recv_dv),
    .recv_64bit     (recv_64bit),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .clr_overflow   (clr_overflow),
    .frame_err      (frame_err),
    .ovf_cnt        (ovf_cnt),
    .ferr_cnt       (ferr_cnt)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [63:0] q_got [$];
  int          q_cyc [$];
  logic [63:0] exp_q [$];

  always @(posedge CLK100MHZ) cyc <= cyc + 1;

  // capture every delivered word with its cycle stamp
  always @(negedge CLK100MHZ) begin
    if (recv_dv) begin
      q_got.push_back(recv_64bit);
      q_cyc.push_back(cyc);
    end
  end

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK100MHZ);
    #1;
  endtask

  // Sends the first n bytes of w back to back, MSB first. With the checksum
  // build a full word is followed by its XOR byte (corrupted if bad_chk).
  task automatic send_seq(input logic [63:0] w, input int n, input bit bad_chk);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      step(1);
      rx_dv   = 1'b1;
      rx_byte = w[63-8*i -: 8];
      x       = x ^ w[63-8*i -: 8];
    end
`ifdef SPHERE_CHECKSUM_EN
    if (n == 8) begin
      step(1);
      rx_dv   = 1'b1;
      rx_byte = bad_chk ? ~x : x;
    end
`else
    if (bad_chk) x = 8'h00;
`endif
    step(1);
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic check_drain(input string tag);
    check_vec({tag, "_n"}, 64'(q_got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < q_got.size(); i++)
      check_vec($sformatf("%s_w%0d", tag, i), q_got[i], exp_q[i]);
    for (int i = 1; i < q_cyc.size(); i++)
      check_vec($sformatf("%s_gap%0d", tag, i), 64'(q_cyc[i] - q_cyc[i-1]), 64'd2);
  endtask

  task automatic clear_caps();
    q_got.delete();
    q_cyc.delete();
    exp_q.delete();
  endtask

  localparam logic [63:0] W0 = 64'h0064FE7000C8A000;
  localparam logic [63:0] WA = 64'h1122334455667788;
  localparam logic [63:0] WB = 64'h99AABBCCDDEEFF00;
  localparam logic [63:0] WC = 64'h0123456789ABCDEF;
  localparam logic [63:0] WD = 64'hFEDCBA9876543210;
  localparam logic [63:0] WE = 64'hA5A55A5AC3C33C3C;
  localparam logic [63:0] WF = 64'h0F0F0F0FF0F0F0F0;
  localparam logic [63:0] WG = 64'h8000000000000001;

  initial begin
    ck_rst_        = 1'b0;
    spi_cs_n       = 1'b1;
    rx_dv          = 1'b0;
    rx_byte        = 8'h00;
    recv_interrupt = 1'b0;
    clr_overflow   = 1'b0;
    step(3);
    check_vec("rst_dv",    64'(recv_dv), 64'd0);
    check_vec("rst_data",  recv_64bit, 64'd0);
    check_vec("rst_count", 64'(fifo_count), 64'd0);
    check_vec("rst_ovf",   64'(overflow), 64'd0);
    check_vec("rst_ferr",  64'(frame_err), 64'd0);
    check_vec("rst_ovfc",  64'(ovf_cnt), 64'd0);
    check_vec("rst_ferrc", 64'(ferr_cnt), 64'd0);
    ck_rst_  = 1'b1;
    spi_cs_n = 1'b0;
    step(2);

    // single word, exact latency
    recv_interrupt = 1'b1;
    send_seq(W0, 8, 1'b0);
    check_vec("w0_cnt_a", 64'(fifo_count), 64'd0);
    step(1);
    check_vec("w0_cnt_b", 64'(fifo_count), 64'd1);
    check_vec("w0_dv_b",  64'(recv_dv), 64'd0);
    step(1);
    check_vec("w0_dv",    64'(recv_dv), 64'd1);
    check_vec("w0_data",  recv_64bit, W0);
    check_vec("w0_cnt_c", 64'(fifo_count), 64'd0);
    step(1);
    check_vec("w0_dv_off", 64'(recv_dv), 64'd0);
    check_vec("w0_hold",   recv_64bit, W0);
    clear_caps();

    // six words into a four-deep FIFO, then drain
    recv_interrupt = 1'b0;
    send_seq(WA, 8, 1'b0);
    send_seq(WB, 8, 1'b0);
    send_seq(WC, 8, 1'b0);
    send_seq(WD, 8, 1'b0);
    send_seq(WE, 8, 1'b0);
    send_seq(WF, 8, 1'b0);
    step(2);
    check_vec("ovf_count", 64'(fifo_count), 64'd4);
    check_vec("ovf_flag",  64'(overflow), 64'd1);
    check_vec("ovf_cnt",   64'(ovf_cnt), 64'd2);
    recv_interrupt = 1'b1;
    step(12);
    exp_q = '{WA, WB, WC, WD};
    check_drain("ovf_drain");
    check_vec("ovf_empty", 64'(fifo_count), 64'd0);
    clear_caps();
    clr_overflow = 1'b1;
    step(1);
    clr_overflow = 1'b0;
    check_vec("clr_flag", 64'(overflow), 64'd0);
    check_vec("clr_cnt",  64'(ovf_cnt), 64'd0);

    // chip select abort after five bytes
    send_seq(WB, 5, 1'b0);
    spi_cs_n = 1'b1;
    step(1);
    check_vec("cs_ferr",   64'(frame_err), 64'd1);
    check_vec("cs_ferrc",  64'(ferr_cnt), 64'd1);
    spi_cs_n = 1'b0;
    step(1);
    check_vec("cs_pulse",  64'(frame_err), 64'd0);
    check_vec("cs_nopush", 64'(fifo_count), 64'd0);
    send_seq(WC, 8, 1'b0);
    step(4);
    exp_q = '{WC};
    check_drain("cs_next");
    clear_caps();

    // idle timeout after three bytes
    send_seq(WD, 3, 1'b0);
    step(TIMEOUT);
    check_vec("tmo_early", 64'(frame_err), 64'd0);
    step(1);
    check_vec("tmo_ferr",  64'(frame_err), 64'd1);
    check_vec("tmo_ferrc", 64'(ferr_cnt), 64'd2);
    send_seq(WE, 8, 1'b0);
    step(4);
    exp_q = '{WE};
    check_drain("tmo_next");
    clear_caps();

    // full FIFO, push and pop in the same cycle
    recv_interrupt = 1'b0;
    send_seq(WA, 8, 1'b0);
    send_seq(WB, 8, 1'b0);
    send_seq(WC, 8, 1'b0);
    send_seq(WD, 8, 1'b0);
    step(2);
    check_vec("full_count", 64'(fifo_count), 64'd4);
    send_seq(WE, 8, 1'b0);
    recv_interrupt = 1'b1;
    step(1);
    recv_interrupt = 1'b0;
    check_vec("pp_count", 64'(fifo_count), 64'd4);
    check_vec("pp_ovf",   64'(overflow), 64'd0);
    check_vec("pp_ovfc",  64'(ovf_cnt), 64'd0);
    check_vec("pp_dv",    64'(recv_dv), 64'd1);
    check_vec("pp_data",  recv_64bit, WA);
    // clear coinciding with a drop
    send_seq(WF, 8, 1'b0);
    clr_overflow = 1'b1;
    step(1);
    clr_overflow = 1'b0;
    check_vec("clrdrop_ovf",  64'(overflow), 64'd0);
    check_vec("clrdrop_ovfc", 64'(ovf_cnt), 64'd0);
    check_vec("clrdrop_cnt",  64'(fifo_count), 64'd4);
    send_seq(WG, 8, 1'b0);
    step(2);
    check_vec("drop_ovf",  64'(overflow), 64'd1);
    check_vec("drop_ovfc", 64'(ovf_cnt), 64'd1);
    clear_caps();
    recv_interrupt = 1'b1;
    step(12);
    exp_q = '{WB, WC, WD, WE};
    check_drain("pp_drain");
    check_vec("pp_empty", 64'(fifo_count), 64'd0);
    clear_caps();

`ifdef SPHERE_CHECKSUM_EN
    send_seq(WC, 8, 1'b1);
    step(4);
    check_vec("chk_bad_n",    64'(q_got.size()), 64'd0);
    check_vec("chk_bad_ferr", 64'(ferr_cnt), 64'd3);
    send_seq(WD, 8, 1'b0);
    step(4);
    exp_q = '{WD};
    check_drain("chk_good");
    clear_caps();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
